// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch counter table controller.
// Counters are 2-bit saturating; update entries carry index and outcome.
package bp_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_MAX = 2'd3;
  localparam bp_ctr_t CTR_MIN = 2'd0;

  // Widest index any legal IDX_BITS can need (pc[31:2]).
  localparam int IDX_W_MAX = 30;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RMW
  } bp_state_e;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 taken;
  } bp_upd_t;

  function automatic bp_ctr_t bp_sat_upd(
    input bp_ctr_t c,
    input logic    taken
  );
    bp_ctr_t r;
    r = c;
    if (taken && (c != CTR_MAX)) begin
      r = c + 2'd1;
    end else if (!taken && (c != CTR_MIN)) begin
      r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO of pending counter updates.
// Push and pop may both take effect in the same cycle.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  bp_upd_t din_i,
  output bp_upd_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);

  bp_upd_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Counter table sequencer: init sweep, lookups, read-modify-write updates.
// Define BP_GSHARE_EN to XOR a global history register into the index.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int      IDX_BITS  = 10,
  parameter int      UPD_DEPTH = 4,
  parameter bp_ctr_t INIT_VAL  = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pred_req_valid,
  input  logic [31:0]         pred_req_pc,
  output logic                pred_req_ready,
  output logic                pred_resp_valid,
  output logic                pred_resp_taken,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  output logic                upd_ready,
  output logic                init_done,
  output logic                tbl_en,
  output logic                tbl_we,
  output logic [IDX_BITS-1:0] tbl_idx,
  output logic [1:0]          tbl_wdata,
  input  logic [1:0]          tbl_rdata
);

  bp_state_e           state_q, state_d;
  logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;
  logic                resp_vld_q;

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [IDX_BITS-1:0] head_idx;
  bp_upd_t             push_data;
  bp_upd_t             head;
  logic                push, pop;
  logic                full, empty;
  logic                lk_go;

  logic                en_d, we_d;
  logic [IDX_BITS-1:0] idx_d;
  bp_ctr_t             wdata_d;

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (push) begin
      ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken};
    end
  end

  assign pred_idx = pred_req_pc[IDX_BITS+1:2] ^ ghr_q;
  assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ ghr_q;
`else
  assign pred_idx = pred_req_pc[IDX_BITS+1:2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
`endif

  logic unused_bits;
  assign unused_bits = ^{pred_req_pc[31:IDX_BITS+2],
                         pred_req_pc[1:0],
                         upd_pc[31:IDX_BITS+2],
                         upd_pc[1:0],
                         head.idx[IDX_W_MAX-1:IDX_BITS]};

  assign push      = upd_valid && !full;
  assign upd_ready = !full;
  assign push_data = '{idx: IDX_W_MAX'(upd_idx),
                       taken: upd_taken};
  assign head_idx  = head.idx[IDX_BITS-1:0];

  bp_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_data),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_done_d    = init_done_q;
    en_d           = 1'b0;
    we_d           = 1'b0;
    idx_d          = '0;
    wdata_d        = '0;
    pop            = 1'b0;
    lk_go          = 1'b0;
    pred_req_ready = 1'b0;
    unique case (state_q)
      INIT: begin
        en_d       = 1'b1;
        we_d       = 1'b1;
        idx_d      = init_cnt_q;
        wdata_d    = INIT_VAL;
        init_cnt_d = init_cnt_q + IDX_BITS'(1);
        if (init_cnt_q == '1) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        // A full FIFO locks out lookups so updates drain.
        pred_req_ready = !full;
        if (pred_req_valid && !full) begin
          lk_go = 1'b1;
          en_d  = 1'b1;
          idx_d = pred_idx;
        end else if (!empty) begin
          en_d    = 1'b1;
          idx_d   = head_idx;
          state_d = RMW;
        end
      end
      RMW: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        idx_d   = head_idx;
        wdata_d = bp_sat_upd(tbl_rdata, head.taken);
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      resp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      resp_vld_q  <= lk_go;
    end
  end

  // Port held idle while reset is asserted.
  assign tbl_en    = rst_n ? en_d : 1'b0;
  assign tbl_we    = rst_n ? we_d : 1'b0;
  assign tbl_idx   = rst_n ? idx_d : '0;
  assign tbl_wdata = rst_n ? wdata_d : '0;

  assign pred_resp_valid = resp_vld_q;
  assign pred_resp_taken = resp_vld_q & tbl_rdata[1];
  assign init_done       = init_done_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl (IDX_BITS=4, UPD_DEPTH=4); honours BP_GSHARE_EN.
// Directed scenarios plus a random run against a queue/array model.
`timescale 1ns/1ps
module tb_bp_table_ctrl;

  localparam int IW  = 4;
  localparam int DEP = 4;
  localparam int N   = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pred_req_valid = 1'b0;
  logic [31:0]   pred_req_pc = '0;
  logic          pred_req_ready;
  logic          pred_resp_valid;
  logic          pred_resp_taken;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic          upd_ready;
  logic          init_done;
  logic          tbl_en;
  logic          tbl_we;
  logic [IW-1:0] tbl_idx;
  logic [1:0]    tbl_wdata;
  logic [1:0]    tbl_rdata;

  logic [1:0]    mem [N];
  logic [IW-1:0] m_ghr = '0;
  int            vectors = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  bp_table_ctrl #(
    .IDX_BITS  (IW),
    .UPD_DEPTH (DEP),
    .INIT_VAL  (2'b01)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_req_valid  (pred_req_valid),
    .pred_req_pc     (pred_req_pc),
    .pred_req_ready  (pred_req_ready),
    .pred_resp_valid (pred_resp_valid),
    .pred_resp_taken (pred_resp_taken),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_ready       (upd_ready),
    .init_done       (init_done),
    .tbl_en          (tbl_en),
    .tbl_we          (tbl_we),
    .tbl_idx         (tbl_idx),
    .tbl_wdata       (tbl_wdata),
    .tbl_rdata       (tbl_rdata)
  );

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_idx] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_idx];
    end
  end

  function automatic logic [IW-1:0] pidx(input logic [31:0] pc);
    return pc[IW+1:2] ^ m_ghr;
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c,
                                     input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return v[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tbl_en, tbl_we, tbl_idx, tbl_wdata, init_done,
         pred_resp_valid, pred_req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outs: en=%b we=%b idx=%0d wd=%b done=%b rv=%b rdy=%b, want all 0",
               tbl_en, tbl_we, tbl_idx, tbl_wdata, init_done,
               pred_resp_valid, pred_req_ready);
    end
    vectors++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_upd_ready: got %b want 1", upd_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (tbl_en !== 1'b1 || tbl_idx !== IW'(i)) begin
        errors++;
        $display("FAIL part_init%0d: en=%b idx=%0d want 1 %0d",
                 i, tbl_en, tbl_idx, i);
      end
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (tbl_en !== 1'b0 || tbl_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_init: en=%b we=%b want 0 0", tbl_en, tbl_we);
    end
    tick();
    rst_n = 1'b1;
    pred_req_valid = 1'b1;
    pred_req_pc = 32'h14;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vectors++;
      if ({tbl_en, tbl_we, tbl_idx, tbl_wdata} !== {2'b11, IW'(i), 2'b01} ||
          pred_req_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_cyc%0d: en=%b we=%b idx=%0d wd=%b rdy=%b done=%b, want 1 1 %0d 01 0 0",
                 i, tbl_en, tbl_we, tbl_idx, tbl_wdata,
                 pred_req_ready, init_done, i);
      end
      tick();
    end
    pred_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || tbl_en !== 1'b0 || pred_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_end: done=%b en=%b rdy=%b want 1 0 1",
               init_done, tbl_en, pred_req_ready);
    end
    tick();
  endtask

  task automatic test_lookup();
    pred_req_valid = 1'b1;
    pred_req_pc = 32'h14;
    @(negedge clk);
    vectors++;
    if (pred_req_ready !== 1'b1 || tbl_en !== 1'b1 ||
        tbl_we !== 1'b0 || tbl_idx !== 4'd5 || pred_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lookup_req: rdy=%b en=%b we=%b idx=%0d rv=%b want 1 1 0 5 0",
               pred_req_ready, tbl_en, tbl_we, tbl_idx, pred_resp_valid);
    end
    tick();
    pred_req_pc = 32'h3C;
    @(negedge clk);
    vectors++;
    if (pred_resp_valid !== 1'b1 || pred_resp_taken !== 1'b0 ||
        tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_idx !== 4'd15) begin
      errors++;
      $display("FAIL lookup_b2b: rv=%b tk=%b en=%b we=%b idx=%0d want 1 0 1 0 15",
               pred_resp_valid, pred_resp_taken, tbl_en, tbl_we, tbl_idx);
    end
    tick();
    pred_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (pred_resp_valid !== 1'b1 || pred_resp_taken !== 1'b0 || tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL lookup_resp2: rv=%b tk=%b en=%b want 1 0 0",
               pred_resp_valid, pred_resp_taken, tbl_en);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pred_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lookup_idle: rv=%b want 0", pred_resp_valid);
    end
    tick();
  endtask

  task automatic test_update();
    logic [1:0] exp_w [3] = '{2'b10, 2'b11, 2'b11};
    int   nwr = 0;
    int   nen = 0;
    logic prev_rd = 1'b0;
    for (int c = 0; c < 12; c++) begin
      upd_valid = (c < 3);
      upd_pc = 32'h14;
      upd_taken = 1'b1;
      @(negedge clk);
      if (c < 3) begin
        vectors++;
        if (upd_ready !== 1'b1) begin
          errors++;
          $display("FAIL upd_ready%0d: got %b want 1", c, upd_ready);
        end
      end
      if (tbl_en === 1'b1) nen++;
      if (tbl_en === 1'b1 && tbl_we === 1'b1) begin
        vectors++;
        if (nwr > 2 || !prev_rd || tbl_idx !== 4'd5 ||
            tbl_wdata !== exp_w[nwr > 2 ? 2 : nwr]) begin
          errors++;
          $display("FAIL upd_write%0d: idx=%0d wd=%b prev_rd=%b want 5 %b 1",
                   nwr, tbl_idx, tbl_wdata, prev_rd,
                   exp_w[nwr > 2 ? 2 : nwr]);
        end
        nwr++;
      end
      prev_rd = (tbl_en === 1'b1) && (tbl_we === 1'b0) && (tbl_idx === 4'd5);
      tick();
    end
    upd_valid = 1'b0;
    vectors++;
    if (nwr != 3 || nen != 6) begin
      errors++;
      $display("FAIL upd_cycles: writes=%0d port_cycles=%0d want 3 6", nwr, nen);
    end
  endtask

  task automatic test_full();
    logic [0:10] pv = 11'b11111110000;
    logic [0:10] uv = 11'b11111000110;
    logic [0:10] ut = 11'b11011000100;
    logic [0:10] er = 11'b11110011010;
    logic [0:10] eu = 11'b11110011110;
    int          ui [11] = '{2, 2, 2, 2, 12, 0, 0, 0, 13, 14, 0};
    int          ex_i [6] = '{2, 2, 2, 2, 13, 14};
    logic [1:0]  ex_v [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
    int          wi [$];
    logic [1:0]  wv [$];
    for (int c = 0; c < 28; c++) begin
      if (c < 11) begin
        pred_req_valid = pv[c];
        pred_req_pc = 32'h14;
        upd_valid = uv[c];
        upd_pc = 32'(ui[c] << 2);
        upd_taken = ut[c];
      end else begin
        pred_req_valid = 1'b0;
        upd_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 11) begin
        vectors++;
        if (pred_req_ready !== er[c] || upd_ready !== eu[c]) begin
          errors++;
          $display("FAIL full_c%0d: pred_rdy=%b upd_rdy=%b want %b %b",
                   c, pred_req_ready, upd_ready, er[c], eu[c]);
        end
      end
      if (tbl_en === 1'b1 && tbl_we === 1'b1) begin
        wi.push_back(int'(tbl_idx));
        wv.push_back(tbl_wdata);
      end
      tick();
    end
    vectors++;
    if (wi.size() != 6) begin
      errors++;
      $display("FAIL full_nwr: got %0d writes want 6", wi.size());
    end
    for (int k = 0; k < 6 && k < wi.size(); k++) begin
      vectors++;
      if (wi[k] != ex_i[k] || wv[k] !== ex_v[k]) begin
        errors++;
        $display("FAIL full_wr%0d: idx=%0d wd=%b want %0d %b",
                 k, wi[k], wv[k], ex_i[k], ex_v[k]);
      end
    end
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    upd_valid = 1'b1;
    upd_pc = 32'h0;
    upd_taken = 1'b1;
    tick();
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    repeat (8) tick();
    pred_req_valid = 1'b1;
    pred_req_pc = 32'h14;
    @(negedge clk);
    vectors++;
    if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_idx !== 4'd7) begin
      errors++;
      $display("FAIL gshare_idx: en=%b we=%b idx=%0d want 1 0 7",
               tbl_en, tbl_we, tbl_idx);
    end
    tick();
    pred_req_valid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0]    rt [N];
    logic [IW-1:0] q_i [$];
    logic          q_t [$];
    logic          wr_due = 1'b0;
    logic          lk_prev = 1'b0;
    logic          exp_tk = 1'b0;
    logic          lk, exp_pr, exp_ur, ok;
    logic          e_en, e_we;
    logic [IW-1:0] e_idx;
    logic [1:0]    e_wd;
    pred_req_valid = 1'b0;
    upd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ghr = '0;
    for (int i = 0; i < N; i++) rt[i] = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (init_done === 1'b1) ok = 1'b1;
      tick();
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_init: init_done=%b after 40 cycles want 1", init_done);
    end
    for (int c = 0; c < 500; c++) begin
      if (c < 400) begin
        pred_req_valid = 1'($urandom_range(0, 1));
        pred_req_pc = $urandom;
        upd_valid = ($urandom_range(0, 2) == 0);
        upd_pc = $urandom;
        upd_taken = 1'($urandom_range(0, 1));
      end else begin
        pred_req_valid = 1'b0;
        upd_valid = 1'b0;
      end
      @(negedge clk);
      exp_ur = (q_i.size() < DEP);
      exp_pr = !wr_due && exp_ur;
      vectors++;
      if (pred_req_ready !== exp_pr || upd_ready !== exp_ur) begin
        errors++;
        $display("FAIL rand_rdy c%0d: pred_rdy=%b upd_rdy=%b want %b %b",
                 c, pred_req_ready, upd_ready, exp_pr, exp_ur);
      end
      vectors++;
      if (pred_resp_valid !== lk_prev ||
          (lk_prev && pred_resp_taken !== exp_tk)) begin
        errors++;
        $display("FAIL rand_resp c%0d: rv=%b tk=%b want %b %b",
                 c, pred_resp_valid, pred_resp_taken, lk_prev, exp_tk);
      end
      lk = pred_req_valid && exp_pr;
      e_en = 1'b0;
      e_we = 1'b0;
      e_idx = '0;
      e_wd = '0;
      if (wr_due) begin
        e_en = 1'b1;
        e_we = 1'b1;
        e_idx = q_i[0];
        e_wd = sat(rt[q_i[0]], q_t[0]);
      end else if (lk) begin
        e_en = 1'b1;
        e_idx = pidx(pred_req_pc);
      end else if (q_i.size() > 0) begin
        e_en = 1'b1;
        e_idx = q_i[0];
      end
      vectors++;
      if (tbl_en !== e_en || tbl_we !== e_we ||
          (e_en && tbl_idx !== e_idx) ||
          (e_we && tbl_wdata !== e_wd)) begin
        errors++;
        $display("FAIL rand_port c%0d: en=%b we=%b idx=%0d wd=%b want %b %b %0d %b",
                 c, tbl_en, tbl_we, tbl_idx, tbl_wdata,
                 e_en, e_we, e_idx, e_wd);
      end
      lk_prev = lk;
      if (lk) exp_tk = rt[pidx(pred_req_pc)][1];
      if (wr_due) begin
        rt[q_i[0]] = e_wd;
        void'(q_i.pop_front());
        void'(q_t.pop_front());
        wr_due = 1'b0;
      end else if (!lk && q_i.size() > 0) begin
        wr_due = 1'b1;
      end
      if (upd_valid && exp_ur) begin
        q_i.push_back(pidx(upd_pc));
        q_t.push_back(upd_taken);
`ifdef BP_GSHARE_EN
        m_ghr = {m_ghr[IW-2:0], upd_taken};
`endif
      end
      tick();
    end
    vectors++;
    if (q_i.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d updates left want 0", q_i.size());
    end
  endtask

  initial begin
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_lookup();
    test_update();
    test_full();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Sequences a single-port, 1-cycle-read-latency table of 2-bit saturating branch counters.
- Serves fetch-side prediction lookups and applies commit-side resolved outcomes as read-modify-write updates through a small update FIFO.
- Initializes the whole table after reset, then arbitrates the port between lookups and updates.
- Sits between the fetch stage, the ROB commit path and the counter-table SRAM.

Parameters:
IDX_BITS, 10, table index width; the table has 2**IDX_BITS entries.
UPD_DEPTH, 4, update FIFO depth; must be a power of 2 and at least 2.
INIT_VAL, 2'b01, counter value written to every entry during init (weakly not-taken).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pred_req_valid  in  1  lookup request
pred_req_pc  in  32  PC to predict
pred_req_ready  out  1  lookup accepted this cycle
pred_resp_valid  out  1  prediction valid, one cycle after acceptance
pred_resp_taken  out  1  predicted direction
upd_valid  in  1  resolved branch outcome
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_ready  out  1  update FIFO not full
init_done  out  1  table initialization complete
tbl_en  out  1  table port enable
tbl_we  out  1  table write enable
tbl_idx  out  IDX_BITS  table address
tbl_wdata  out  2  write data
tbl_rdata  in  2  read data, valid the cycle after a read

Behaviour:
- Reset (async assert, sync release): state=INIT, init counter=0, FIFO empty, pred_resp_valid=0, init_done=0, all tbl_* outputs 0.
- Index: idx = pc[IDX_BITS+1:2].
- INIT state:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_idx=init counter, tbl_wdata=INIT_VAL; counter increments.
  - After the write to the last index, go to IDLE and set init_done=1. Init takes 2**IDX_BITS cycles.
  - pred_req_ready=0 throughout.
  - upd_ready follows the FIFO state, so updates can be enqueued during INIT.
- Update enqueue: when upd_valid && upd_ready, push {idx(upd_pc), upd_taken}. upd_ready = !fifo_full in every state.
- IDLE state, grant priority:
  - Lookup: pred_req_ready = !fifo_full. On acceptance: tbl_en=1, tbl_we=0, tbl_idx=idx(pred_req_pc). Next cycle: pred_resp_valid=1 and pred_resp_taken=tbl_rdata[1]. Stay in IDLE; back-to-back lookups run at 1 per cycle.
  - Otherwise, if the FIFO is not empty: issue a read of the head index and go to RMW.
  - A full FIFO blocks lookups, which guarantees updates drain.
- RMW state (1 cycle):
  - Compute new = rdata+1 if taken && rdata!=3; rdata-1 if !taken && rdata!=0; else rdata.
  - Drive tbl_en=1, tbl_we=1, tbl_idx=head idx, tbl_wdata=new. Pop the FIFO and return to IDLE.
  - pred_req_ready=0. An update occupies the port for 2 cycles.
- Simultaneous push and pop in one cycle: both take effect; occupancy is unchanged.
- Push and pop pointers wrap modulo UPD_DEPTH.
- No forwarding: a lookup to an index with a pending update returns the stale table value. Consecutive updates to the same index are serialized, so no increment is lost.
- pred_resp_valid is 0 in every cycle not immediately following an accepted lookup.
- Reset asserted mid-RMW or mid-INIT: state aborts immediately and init restarts from index 0.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Add an IDX_BITS-wide global history register, reset to 0.
  - Lookup and enqueue indices become idx(pc) ^ ghr. The enqueue index is computed with the ghr value before the shift.
  - On each enqueue, ghr <= {ghr[IDX_BITS-2:0], upd_taken}.
- Undefined: no history register; indexing uses PC bits only.

Decomposition:
- Package bp_pkg holds:
  - bp_ctr_t (2-bit counter typedef);
  - bp_state_e {INIT, IDLE, RMW};
  - bp_upd_t struct {idx, taken};
  - a saturating-update function;
  - the CTR_MAX=3 and CTR_MIN=0 constants.
- One sub-module, bp_upd_fifo: parameterized synchronous FIFO of bp_upd_t with full/empty flags and same-cycle push/pop.

Test Plan:
- Reset, IDX_BITS=4 -> exactly 16 write cycles to idx 0..15 with wdata=01; init_done rises on cycle 16; pred_req_ready=0 until then.
- After init, lookup pc=0x14 -> tbl_idx=5, tbl_we=0; next cycle pred_resp_valid=1, pred_resp_taken=0.
- Three taken updates to pc=0x14, no lookups -> writes to idx 5 of 10, 11, 11 (saturates); each update takes 2 port cycles.
- pred_req_valid held high while 4 updates are enqueued (UPD_DEPTH=4) -> pred_req_ready drops when the FIFO is full, an RMW runs, then lookups resume.
- upd_valid asserted while the FIFO is full -> upd_ready=0 and the entry is not pushed; a push and pop in the same cycle keeps occupancy constant.
- With BP_GSHARE_EN: enqueue taken then not-taken -> ghr=…10; a lookup of pc=0x14 indexes 5^2=7.
